// File: rtl/normal_reorder_buffer_if.sv
// Handshake bundle for the normal reorder buffer: tag allocation, divider
// write-back, and the in-order result stream with occupancy status.
`ifndef WIDTH
`define WIDTH 16
`endif

interface normal_reorder_buffer_if #(
  parameter int WIDTH    = `WIDTH,
  parameter int TAG_BITS = 5
);
  logic                  alloc_req;
  logic                  alloc_gnt;
  logic [TAG_BITS-1:0]   alloc_tag;
  logic                  wr_valid;
  logic [TAG_BITS-1:0]   wr_tag;
  logic [3*WIDTH-1:0]    wr_data;   // {x, y, z}
  logic                  out_valid;
  logic                  out_ready;
  logic [3*WIDTH-1:0]    out_data;  // {x, y, z}
  logic [TAG_BITS-1:0]   out_tag;
  logic [TAG_BITS:0]     count;
  logic                  full;
  logic                  err;

  modport master (
    output alloc_req, wr_valid, wr_tag, wr_data, out_ready,
    input  alloc_gnt, alloc_tag, out_valid, out_data, out_tag, count, full, err
  );

  modport slave (
    input  alloc_req, wr_valid, wr_tag, wr_data, out_ready,
    output alloc_gnt, alloc_tag, out_valid, out_data, out_tag, count, full, err
  );
endinterface

// File: rtl/normal_reorder_buffer.sv
// Reorder buffer for normalized ray directions: tags are handed out in order,
// results arrive in any order, and retire strictly in allocation order.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 8
`endif

module normal_reorder_buffer #(
  parameter int WIDTH    = `WIDTH,
  parameter int Q_BITS   = `Q_BITS,
  parameter int TAG_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  normal_reorder_buffer_if.slave bus
);
  localparam int DEPTH = 1 << TAG_BITS;
  localparam int CW    = TAG_BITS + 1;

  typedef struct packed {
    logic [WIDTH-Q_BITS-1:0] ip;
    logic [Q_BITS-1:0]       fp;
  } fix_t;

  typedef struct packed {
    fix_t x;
    fix_t y;
    fix_t z;
  } ray_dir_t;

  logic [TAG_BITS-1:0] head_q, tail_q;
  logic [CW-1:0]       cnt_q;
  logic [DEPTH-1:0]    alloc_q, done_q;
  logic                err_q;
  ray_dir_t            mem [DEPTH];

  logic gnt, retire, wr_ok, wr_bad, full, out_valid;

  assign full      = (cnt_q == CW'(DEPTH));
  // full refuses allocation even if the head retires in the same cycle
  assign gnt       = bus.alloc_req & ~full & ~reset;
  assign out_valid = alloc_q[head_q] & done_q[head_q];
  assign retire    = out_valid & bus.out_ready;
  // alloc/done are sampled before this edge, so same-cycle alloc or retire of wr_tag is illegal
  assign wr_ok     = bus.wr_valid & alloc_q[bus.wr_tag] & ~done_q[bus.wr_tag];
  assign wr_bad    = bus.wr_valid & ~wr_ok;

  assign bus.alloc_gnt = gnt;
  assign bus.alloc_tag = tail_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem[head_q] : '0;
  assign bus.out_tag   = out_valid ? head_q : '0;
  assign bus.count     = cnt_q;
  assign bus.full      = full;
  assign bus.err       = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (gnt)    tail_q <= tail_q + 1'b1;
      if (retire) head_q <= head_q + 1'b1;
      cnt_q <= cnt_q + CW'(gnt) - CW'(retire);
      err_q <= wr_bad;
    end
  end

  // Allocation and retire can never target the same entry: that would need
  // head == tail with entries live, i.e. full, where allocation is refused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (gnt && tail_q == TAG_BITS'(i)) begin
          alloc_q[i] <= 1'b1;
          done_q[i]  <= 1'b0;
        end else if (retire && head_q == TAG_BITS'(i)) begin
          alloc_q[i] <= 1'b0;
          done_q[i]  <= 1'b0;
        end else if (wr_ok && bus.wr_tag == TAG_BITS'(i)) begin
          done_q[i]  <= 1'b1;
        end
      end
    end
  end

  // Payload storage is not reset; reads are masked by out_valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.wr_tag] <= ray_dir_t'(bus.wr_data);
  end
endmodule

// File: tb/tb_normal_reorder_buffer.sv
// Directed bench for normal_reorder_buffer: tags queue on allocation, and a
// negedge monitor checks every retired result against the queue in order.
module tb_normal_reorder_buffer;
  localparam int W     = 16;
  localparam int TB    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  normal_reorder_buffer_if #(.WIDTH(W), .TAG_BITS(TB)) bus ();

  normal_reorder_buffer #(.WIDTH(W), .Q_BITS(8), .TAG_BITS(TB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [3*W-1:0] exp_data [DEPTH];
  logic [TB-1:0]  sb [$];
  logic [TB-1:0]  tail_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every retire must match the oldest allocated tag and its data.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        logic [TB-1:0] t;
        t = sb.pop_front();
        chk("out_tag", 64'(bus.out_tag), 64'(t));
        chk("out_data", 64'(bus.out_data), 64'(exp_data[t]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3*W-1:0] rnd();
    return {16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    tail_m = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_alloc(output logic [TB-1:0] t);
    bus.alloc_req = 1'b1;
    @(negedge clk);
    chk("alloc_gnt", 64'(bus.alloc_gnt), 64'd1);
    chk("alloc_tag", 64'(bus.alloc_tag), 64'(tail_m));
    t = bus.alloc_tag;
    sb.push_back(tail_m);
    tail_m = tail_m + 1'b1;
    tick();
    bus.alloc_req = 1'b0;
  endtask

  // exp_valid < 0 skips the out_valid check taken before the write edge
  task automatic wr(input logic [TB-1:0] tag, input logic [3*W-1:0] d,
                    input bit legal, input int exp_valid);
    bus.wr_valid = 1'b1;
    bus.wr_tag   = tag;
    bus.wr_data  = d;
    if (legal) exp_data[tag] = d;
    @(negedge clk);
    if (exp_valid >= 0) chk("pre_wr_valid", 64'(bus.out_valid), 64'(exp_valid));
    tick();
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    logic [TB-1:0]  t, t2;
    logic [3*W-1:0] d, d0;
    int order [4];

    reset = 1'b1;
    bus.alloc_req = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_tag    = '0;
    bus.wr_data   = '0;
    bus.out_ready = 1'b0;
    tail_m = '0;

    // reset state with requests pending
    bus.alloc_req = 1'b1;
    bus.wr_valid  = 1'b1;
    bus.wr_tag    = 5'd3;
    @(negedge clk);
    chk("rst_gnt", 64'(bus.alloc_gnt), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    tick();
    bus.alloc_req = 1'b0;
    bus.wr_valid  = 1'b0;
    reset = 1'b0;
    tick();

    // in-order: first result one cycle after first write, then one per cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) do_alloc(t);
    wr(5'd0, rnd(), 1, 0);
    wr(5'd1, rnd(), 1, 1);
    wr(5'd2, rnd(), 1, 1);
    @(negedge clk);
    chk("inorder_last", 64'(bus.out_valid), 64'd1);
    tick();
    @(negedge clk);
    chk("inorder_empty", 64'(bus.out_valid), 64'd0);
    chk("inorder_count", 64'(bus.count), 64'd0);
    tick();

    // out-of-order: write 3,1,2,0 -> nothing until tag 0, then 0..3 back-to-back
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) do_alloc(t);
    order = '{3, 1, 2, 0};
    foreach (order[k]) wr(TB'(order[k]), rnd(), 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ooo_stream", 64'(bus.out_valid), 64'd1);
      tick();
    end
    @(negedge clk);
    chk("ooo_drained", 64'(bus.out_valid), 64'd0);
    tick();

    // backpressure: head held stable, then simultaneous alloc+retire
    bus.out_ready = 1'b0;
    do_alloc(t);
    d = rnd();
    wr(t, d, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_data", 64'(bus.out_data), 64'(d));
      chk("bp_tag", 64'(bus.out_tag), 64'(t));
      chk("bp_count", 64'(bus.count), 64'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    do_alloc(t2);
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("alloc_retire_count", 64'(bus.count), 64'd1);
    tick();
    wr(t2, rnd(), 1, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_drained", 64'(bus.count), 64'd0);
    tick();

    // errors: unallocated write, duplicate write, write while empty
    do_reset();
    do_alloc(t);
    d0 = rnd();
    wr(5'd0, d0, 1, 0);
    wr(5'd7, rnd(), 0, 1);
    @(negedge clk);
    chk("err_unalloc", 64'(bus.err), 64'd1);
    tick();
    @(negedge clk);
    chk("err_unalloc_clr", 64'(bus.err), 64'd0);
    tick();
    wr(5'd0, ~d0, 0, 1);
    @(negedge clk);
    chk("err_dup", 64'(bus.err), 64'd1);
    chk("err_dup_data", 64'(bus.out_data), 64'(d0));
    tick();
    @(negedge clk);
    chk("err_dup_clr", 64'(bus.err), 64'd0);
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    wr(5'd3, rnd(), 0, 0);
    @(negedge clk);
    chk("err_empty", 64'(bus.err), 64'd1);
    chk("err_empty_count", 64'(bus.count), 64'd0);
    tick();

    // full and wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_alloc(t);
    @(negedge clk);
    chk("full_flag", 64'(bus.full), 64'd1);
    chk("full_count", 64'(bus.count), 64'd32);
    tick();
    bus.alloc_req = 1'b1;
    @(negedge clk);
    chk("full_refuse", 64'(bus.alloc_gnt), 64'd0);
    tick();
    bus.alloc_req = 1'b0;
    wr(5'd0, rnd(), 1, 0);
    bus.out_ready = 1'b1;
    bus.alloc_req = 1'b1;
    @(negedge clk);
    chk("full_retire_refuse", 64'(bus.alloc_gnt), 64'd0);
    tick();
    bus.out_ready = 1'b0;
    bus.alloc_req = 1'b0;
    @(negedge clk);
    chk("after_retire_count", 64'(bus.count), 64'd31);
    chk("after_retire_full", 64'(bus.full), 64'd0);
    tick();
    do_alloc(t);
    chk("wrap_tag", 64'(t), 64'd0);
    @(negedge clk);
    chk("wrap_count", 64'(bus.count), 64'd32);
    tick();

    // reset mid-stream: 10 allocated, 4 written including head
    do_reset();
    for (int i = 0; i < 10; i++) do_alloc(t);
    wr(5'd0, rnd(), 1, 0);
    wr(5'd2, rnd(), 1, 1);
    wr(5'd5, rnd(), 1, 1);
    wr(5'd7, rnd(), 1, 1);
    bus.alloc_req = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", 64'(bus.alloc_gnt), 64'd0);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_data", 64'(bus.out_data), 64'd0);
    chk("mid_rst_tag", 64'(bus.out_tag), 64'd0);
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_full", 64'(bus.full), 64'd0);
    chk("mid_rst_err", 64'(bus.err), 64'd0);
    bus.alloc_req = 1'b0;
    sb.delete();
    tail_m = '0;
    tick();
    reset = 1'b0;
    do_alloc(t);
    chk("post_rst_tag", 64'(t), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/normal_reorder_buffer.md
NORMAL_REORDER_BUFFER -- requirements
Module: normal_reorder_buffer

Interface
REQ-001 Parameter WIDTH, default `WIDTH, bit width of each fixed-point direction component.
REQ-002 Parameter Q_BITS, default `Q_BITS, number of fractional bits; carried for type consistency only, no arithmetic is performed.
REQ-003 Parameter TAG_BITS, default 5, tag width; buffer depth DEPTH = 2**TAG_BITS.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 alloc_req  input  1  upstream requests a tag for a new ray direction.
REQ-007 alloc_gnt  output  1  tag granted this cycle; equals alloc_req & !full.
REQ-008 alloc_tag  output  TAG_BITS  tag issued when alloc_gnt=1 (current tail pointer).
REQ-009 wr_valid  input  1  a divider delivers a normalized result this cycle.
REQ-010 wr_tag  input  TAG_BITS  tag of the delivered result.
REQ-011 wr_data  input  RayDirection (3*WIDTH, x,y,z)  normalized direction.
REQ-012 out_valid  output  1  head entry complete and presented.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_data  output  RayDirection  normalized direction of head entry.
REQ-015 out_tag  output  TAG_BITS  tag of head entry.
REQ-016 count  output  TAG_BITS+1  number of allocated, not yet retired entries.
REQ-017 full  output  1  count == DEPTH.
REQ-018 err  output  1  one-cycle pulse on an illegal write.

Function
REQ-019 State: head and tail pointers (TAG_BITS, wrap modulo DEPTH), count, per-entry alloc and done bits, DEPTH x 3*WIDTH data storage.
REQ-020 Allocate: when alloc_gnt=1, entry[tail].alloc<=1, done<=0, tail<=tail+1 (wraps DEPTH-1 -> 0).
REQ-021 Allocation SHALL be refused (alloc_gnt=0) whenever full=1, even if a retire occurs in the same cycle.
REQ-022 Write: when wr_valid=1 and entry[wr_tag].alloc=1 and done=0, store wr_data and set done<=1.
REQ-023 Illegal write (wr_valid=1 to an entry with alloc=0 or done=1): data and state unchanged, err=1 on the next cycle for exactly one cycle.
REQ-024 out_valid = entry[head].alloc & entry[head].done; out_data/out_tag read combinationally from head entry; out_data=0 when out_valid=0.
REQ-025 Retire: when out_valid & out_ready, clear entry[head].alloc and done, head<=head+1 (wrapping).
REQ-026 Results SHALL leave strictly in allocation order regardless of write arrival order.
REQ-027 Latency: a write to the head entry in cycle N yields out_valid=1 in cycle N+1; no bypass.
REQ-028 out_data and out_tag SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 count <= count + alloc_gnt - retire each cycle; simultaneous allocate and retire leave count unchanged.
REQ-030 Same-cycle write to tag T and retire of head H!=T are both performed; a write to the entry retiring that same cycle is illegal (done=1) per REQ-023.
REQ-031 Simultaneous allocate and write to the same tag is illegal (alloc=0 at the sampling edge) per REQ-023.
REQ-032 Empty (count=0): out_valid=0; any write flags err.

Reset
REQ-033 While reset=1: head=0, tail=0, count=0, all alloc/done bits 0, alloc_gnt=0, out_valid=0, out_data=0, out_tag=0, full=0, err=0; storage contents need not be cleared.
REQ-034 Reset asserted mid-operation discards all in-flight entries; first tag granted after release is 0.

Verification
REQ-035 In-order: allocate tags 0,1,2; write 0,1,2 in order with out_ready=1 -> outputs tags 0,1,2 one per cycle starting one cycle after first write.
REQ-036 Out-of-order: allocate 0..3; write 3,1,2,0 -> out_valid stays 0 until the write of tag 0, then tags 0,1,2,3 emerge on consecutive cycles.
REQ-037 Full/wrap: allocate 32 with TAG_BITS=5 -> full=1, 33rd alloc_req refused; retire one -> next grant returns tag 0, count returns to 32.
REQ-038 Backpressure: head complete with out_ready=0 for 5 cycles -> out_valid=1 and out_data constant; count unchanged.
REQ-039 Errors: write to unallocated tag 7, then duplicate write to allocated tag 0 -> err pulses one cycle each, stored data of tag 0 unchanged.
REQ-040 Reset mid-stream with 10 entries allocated, 4 written -> all outputs 0 immediately, first post-reset alloc_tag=0.
